seq_divider16bit: RTL and testbench

- Multi-cycle 16-bit unsigned restoring divider.
- Computes quotient and remainder by one shift-and-trial-subtract per clock.
- Sits beside the 16-bit adder/subtractor as the inverse operation for the datapath: repeated subtraction instead of addition.
- Uses a start/busy/done handshake so a controller can launch one division and wait for completion.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 31 +++
 rtl/seq_divider16bit.sv | 157 +++++++++++++++
 tb/tb_seq_divider16bit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the 16-bit sequential restoring divider.
// Covers the FSM states, step count, divide-by-zero constant and a sign helper.
package div_pkg;

    localparam int          DIV_WIDTH     = 16;
    localparam logic [3:0]  DIV_LAST_STEP = 4'd15;
    localparam logic [15:0] DIV_ZERO_QUOTIENT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Two's-complement negate when neg is set; used for the signed magnitude fix-ups.
    function automatic logic [15:0] cond_negate(input logic [15:0] x, input logic neg);
        return neg ? (~x + 16'd1) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// The subtractor is a ripple of gate-level full adders computing a + ~b + 1.
module div_step (
    input  logic [15:0] r,
    input  logic        bit_in,
    input  logic [15:0] divisor,
    output logic [15:0] r_next,
    output logic        q_bit
);

    logic [16:0] a;
    logic [16:0] b_n;
    logic [16:0] trial;
    logic [16:0] c;

    assign a    = {r, bit_in};
    assign b_n  = ~{1'b0, divisor};
    assign c[0] = 1'b1;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign trial[i] = a[i] ^ b_n[i] ^ c[i];
        assign c[i+1]   = (a[i] & b_n[i]) | (c[i] & (a[i] ^ b_n[i]));
    end

    // The partial remainder stays below the divisor, so bit 16 is a true sign bit.
    assign trial[16] = a[16] ^ b_n[16] ^ c[16];

    assign q_bit  = ~trial[16];
    assign r_next = q_bit ? trial[15:0] : a[15:0];

endmodule

// File: rtl/seq_divider16bit.sv
// 16-bit sequential restoring divider with a start/busy/done handshake.
// Define SEQ_DIVIDER16BIT_SIGNED_EN to add signed_mode/overflow (two's-complement division).
module seq_divider16bit
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
`ifdef SEQ_DIVIDER16BIT_SIGNED_EN
    input  logic        signed_mode,
    output logic        overflow,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic [1:0]  state_dbg
);

    // Handshake: start is accepted on an edge where busy=0 (IDLE or DONE); busy stays
    // high through RUN, and done pulses for one cycle once quotient/remainder are valid.
    div_state_t  state, next_state;
    logic [3:0]  count;
    logic [15:0] r;
    logic [15:0] dvd_shift;
    logic [15:0] dvsr;
    logic [14:0] q_shift;
    logic        accept;
    logic        dvsr_zero;
    logic        last_step;
    logic        step_q;
    logic [15:0] step_r;
    logic [15:0] q_raw;
    logic [15:0] q_final;
    logic [15:0] r_final;
    logic [15:0] dvd_in;
    logic [15:0] dvsr_in;
    logic [15:0] dvd_orig;

    assign accept    = start && (state != RUN);
    assign dvsr_zero = (dvsr == 16'd0);
    assign last_step = (count == DIV_LAST_STEP);
    assign q_raw     = {q_shift, step_q};
    assign state_dbg = state;

    div_step u_step (
        .r       (r),
        .bit_in  (dvd_shift[15]),
        .divisor (dvsr),
        .r_next  (step_r),
        .q_bit   (step_q)
    );

`ifdef SEQ_DIVIDER16BIT_SIGNED_EN
    logic smode;
    logic neg_q;
    logic neg_r;

    // The core always divides magnitudes; signs are applied on the final write.
    assign dvd_in   = cond_negate(dividend, signed_mode & dividend[15]);
    assign dvsr_in  = cond_negate(divisor, signed_mode & divisor[15]);
    assign q_final  = cond_negate(q_raw, neg_q);
    assign r_final  = cond_negate(step_r, neg_r);
    assign dvd_orig = cond_negate(dvd_shift, neg_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smode    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            smode    <= signed_mode;
            neg_q    <= signed_mode & (dividend[15] ^ divisor[15]);
            neg_r    <= signed_mode & dividend[15];
            overflow <= 1'b0;
        end else if (state == RUN && !dvsr_zero && last_step) begin
            // A positive signed quotient with bit 15 set only arises from 8000/FFFF.
            overflow <= smode & ~neg_q & q_raw[15];
        end
    end
`else
    assign dvd_in   = dividend;
    assign dvsr_in  = divisor;
    assign q_final  = q_raw;
    assign r_final  = step_r;
    assign dvd_orig = dvd_shift;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (dvsr_zero || last_step) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= 4'd0;
            r           <= 16'd0;
            dvd_shift   <= 16'd0;
            dvsr        <= 16'd0;
            q_shift     <= 15'd0;
            quotient    <= 16'd0;
            remainder   <= 16'd0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count       <= 4'd0;
            r           <= 16'd0;
            dvd_shift   <= dvd_in;
            dvsr        <= dvsr_in;
            q_shift     <= 15'd0;
            div_by_zero <= 1'b0;
        end else if (state == RUN) begin
            if (dvsr_zero) begin
                // Zero divisor finishes after a single RUN cycle with the operand untouched.
                quotient    <= DIV_ZERO_QUOTIENT;
                remainder   <= dvd_orig;
                div_by_zero <= 1'b1;
            end else begin
                r         <= step_r;
                dvd_shift <= {dvd_shift[14:0], 1'b0};
                q_shift   <= q_raw[14:0];
                count     <= count + 4'd1;
                if (last_step) begin
                    quotient  <= q_final;
                    remainder <= r_final;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider16bit.sv
// Directed bench for seq_divider16bit: driver tasks push expected results and done
// cycles into queues; a negedge monitor pops and compares on every done pulse.
module tb_seq_divider16bit;
    import div_pkg::*;

    localparam int W = 34;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = 16'd0;
    logic [15:0] divisor = 16'd0;
    logic        signed_mode = 1'b0;
    logic        overflow_act;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;
    logic [1:0]  state_dbg;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           ncyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    seq_divider16bit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIVIDER16BIT_SIGNED_EN
        .signed_mode (signed_mode),
        .overflow    (overflow_act),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

`ifndef SEQ_DIVIDER16BIT_SIGNED_EN
    assign overflow_act = 1'b0;
`endif

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [W-1:0] pack(input logic ovf, input logic dbz,
                                          input logic [15:0] q, input logic [15:0] r);
        return {ovf, dbz, q, r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; the following edge accepts the start.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic sm,
                          input logic [W-1:0] exp, input int lat);
        exp_q.push_back(exp);
        lat_q.push_back(ncyc + lat + 2);
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        start       = 1'b1;
        step(1);
        start       = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        ncyc++;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 34'(done), 34'(0));
            end else begin
                check("result", pack(overflow_act, div_by_zero, quotient, remainder), exp_q.pop_front());
                check("done_cycle", 34'(ncyc), 34'(lat_q.pop_front()));
                check("busy_in_done", 34'(busy), 34'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        step(2);
        check("reset_outputs", pack(overflow_act, div_by_zero, quotient, remainder), pack(0, 0, 16'h0, 16'h0));
        check("reset_state", 34'(state_dbg), 34'(IDLE));
        reset = 1'b0;
        step(1);

        launch(16'd100, 16'd7, 1'b0, pack(0, 0, 16'd14, 16'd2), 16);
        check("busy_running", 34'(busy), 34'(1));
        step(18);

        // back-to-back: second start held in the first DONE cycle
        launch(16'hFFFF, 16'd1, 1'b0, pack(0, 0, 16'hFFFF, 16'h0), 16);
        step(16);
        launch(16'h1234, 16'hFFFF, 1'b0, pack(0, 0, 16'h0, 16'h1234), 16);
        step(18);

        launch(16'd5, 16'd0, 1'b0, pack(0, 1, 16'hFFFF, 16'd5), 1);
        step(2);
        launch(16'd9, 16'd3, 1'b0, pack(0, 0, 16'd3, 16'd0), 16);
        step(18);

        // start during RUN must be ignored
        launch(16'd1000, 16'd10, 1'b0, pack(0, 0, 16'd100, 16'd0), 16);
        step(3);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
        step(16);

        launch(16'd50000, 16'd123, 1'b0, pack(0, 0, 16'd406, 16'd62), 16);
        step(18);
        launch(16'd7, 16'd9, 1'b0, pack(0, 0, 16'd0, 16'd7), 16);
        step(18);
        launch(16'd65535, 16'd255, 1'b0, pack(0, 0, 16'd257, 16'd0), 16);
        step(18);

        // asynchronous reset mid-run: in-flight result is discarded
        launch(16'd200, 16'd3, 1'b0, pack(0, 0, 16'd66, 16'd2), 16);
        step(7);
        exp_q.delete();
        lat_q.delete();
        reset = 1'b1;
        #1;
        check("async_reset_outputs", pack(overflow_act, div_by_zero, quotient, remainder), pack(0, 0, 16'h0, 16'h0));
        check("async_reset_flags", {32'd0, busy, done}, 34'(0));
        step(2);
        reset = 1'b0;
        step(20);
        launch(16'd81, 16'd9, 1'b0, pack(0, 0, 16'd9, 16'd0), 16);
        step(18);

`ifdef SEQ_DIVIDER16BIT_SIGNED_EN
        launch(16'hFFF9, 16'd2, 1'b1, pack(0, 0, 16'hFFFD, 16'hFFFF), 16);
        step(18);
        launch(16'h8000, 16'hFFFF, 1'b1, pack(1, 0, 16'h8000, 16'h0), 16);
        step(18);
        launch(16'hFFF9, 16'd0, 1'b1, pack(0, 1, 16'hFFFF, 16'hFFF9), 1);
        step(3);
`endif

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step(1);
        check("queue_drained", 34'(exp_q.size()), 34'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
